// File: rtl/eth_mii_rx_axis_pkg.sv
// Shared Ethernet receive constants and the receive FSM state type.
package eth_mii_rx_axis_pkg;

    localparam logic [3:0]  ETH_PREAMBLE_NIBBLE = 4'h5;
    localparam logic [3:0]  ETH_SFD_NIBBLE      = 4'hD;
    localparam logic [31:0] ETH_CRC_POLY        = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_RESIDUE     = 32'hDEBB20E3;
    localparam logic [31:0] ETH_CRC_INIT        = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_EOF,
        ST_DROP
    } rx_state_t;

endpackage

// File: rtl/eth_mii_rx_axis_crc32_d8.sv
// Combinational byte-wide Ethernet CRC-32 step (reflected polynomial, no final inversion).
module eth_crc32_d8
    import eth_mii_rx_axis_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_mii_rx_axis.sv
// MII receive front end: nibble assembly, preamble/SFD strip, FCS strip and check,
// 8-bit AXI-stream output with the bad-frame flag on tlast.
//
// state    | meaning
// IDLE     | waiting for dv with a preamble nibble
// PREAMBLE | consuming 5-nibbles until the SFD nibble
// PAYLOAD  | assembling bytes, CRC, FCS delay line, emitting pending byte
// EOF      | dv fell: emit last byte with tlast/tuser and error pulses
// DROP     | discarding until dv falls
module eth_mii_rx_axis
    import eth_mii_rx_axis_pkg::*;
#(
    parameter int unsigned MIN_FRAME_LENGTH = 64,
    parameter int unsigned MAX_FRAME_LENGTH = 1518
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] mii_rxd,
    input  logic       mii_rx_dv,
    input  logic       mii_rx_er,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       busy,
    output logic       error_bad_frame,
    output logic       error_bad_fcs
);

    localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME_LENGTH);
    localparam logic [10:0] MAX_LEN  = 11'(MAX_FRAME_LENGTH);
    localparam logic [10:0] DL_DEPTH = 11'd4;

    rx_state_t       state, state_n;
    logic            phase, phase_n;
    logic [3:0]      lo_nib, lo_nib_n;
    logic [10:0]     count, count_n, count_inc;
    logic [31:0]     crc, crc_n, crc_upd;
    logic            er_flag, er_flag_n;
    logic [3:0][7:0] dl, dl_n;
    logic [7:0]      pend, pend_n;
    logic            pend_valid, pend_valid_n;
    logic [7:0]      tdata_n;
    logic            tvalid_n, tlast_n, tuser_n, ebf_n, efcs_n;
    logic [7:0]      new_byte;
    logic            fcs_bad, frame_bad;

    assign new_byte  = {mii_rxd, lo_nib};
    assign count_inc = (count == 11'h7FF) ? count : count + 11'd1;
    assign fcs_bad   = (crc != ETH_CRC_RESIDUE);
    assign frame_bad = er_flag | phase | fcs_bad | (count < MIN_LEN);
    assign busy      = (state != ST_IDLE);

    eth_crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (new_byte),
        .crc_out (crc_upd)
    );

    always_comb begin
        state_n      = state;
        phase_n      = phase;
        lo_nib_n     = lo_nib;
        count_n      = count;
        crc_n        = crc;
        er_flag_n    = er_flag;
        dl_n         = dl;
        pend_n       = pend;
        pend_valid_n = pend_valid;
        tdata_n      = 8'h00;
        tvalid_n     = 1'b0;
        tlast_n      = 1'b0;
        tuser_n      = 1'b0;
        ebf_n        = 1'b0;
        efcs_n       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mii_rx_dv) begin
                    state_n = (mii_rxd == ETH_PREAMBLE_NIBBLE) ? ST_PREAMBLE : ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (!mii_rx_dv) begin
                    state_n = ST_IDLE;
                end else if (mii_rxd == ETH_SFD_NIBBLE) begin
                    state_n      = ST_PAYLOAD;
                    phase_n      = 1'b0;
                    count_n      = '0;
                    crc_n        = ETH_CRC_INIT;
                    er_flag_n    = 1'b0;
                    pend_valid_n = 1'b0;
                end else if (mii_rxd != ETH_PREAMBLE_NIBBLE) begin
                    state_n = ST_DROP;
                end
            end
            ST_PAYLOAD: begin
                if (!mii_rx_dv) begin
                    state_n = ST_EOF;
                end else begin
                    if (mii_rx_er) er_flag_n = 1'b1;
                    if (!phase) begin
                        lo_nib_n = mii_rxd;
                        phase_n  = 1'b1;
                    end else begin
                        phase_n = 1'b0;
                        if (count >= MAX_LEN) begin
                            // Overlength: this byte is dropped and the frame closed as bad.
                            state_n      = ST_DROP;
                            pend_valid_n = 1'b0;
                            tvalid_n     = pend_valid;
                            tdata_n      = pend;
                            tlast_n      = pend_valid;
                            tuser_n      = pend_valid;
                            ebf_n        = 1'b1;
                        end else begin
                            count_n = count_inc;
                            crc_n   = crc_upd;
                            dl_n    = {dl[2:0], new_byte};
                            if (count >= DL_DEPTH) begin
                                tvalid_n     = pend_valid;
                                tdata_n      = pend;
                                pend_n       = dl[3];
                                pend_valid_n = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_EOF: begin
                state_n      = ST_IDLE;
                pend_valid_n = 1'b0;
                if (pend_valid) begin
                    tvalid_n = 1'b1;
                    tdata_n  = pend;
                    tlast_n  = 1'b1;
                    tuser_n  = frame_bad;
                    ebf_n    = frame_bad;
                    efcs_n   = fcs_bad;
                end else begin
                    ebf_n = 1'b1;
                end
            end
            ST_DROP: begin
                if (!mii_rx_dv) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            phase           <= 1'b0;
            lo_nib          <= '0;
            count           <= '0;
            crc             <= ETH_CRC_INIT;
            er_flag         <= 1'b0;
            dl              <= '0;
            pend            <= '0;
            pend_valid      <= 1'b0;
            m_axis_tdata    <= '0;
            m_axis_tvalid   <= 1'b0;
            m_axis_tlast    <= 1'b0;
            m_axis_tuser    <= 1'b0;
            error_bad_frame <= 1'b0;
            error_bad_fcs   <= 1'b0;
        end else begin
            state           <= state_n;
            phase           <= phase_n;
            lo_nib          <= lo_nib_n;
            count           <= count_n;
            crc             <= crc_n;
            er_flag         <= er_flag_n;
            dl              <= dl_n;
            pend            <= pend_n;
            pend_valid      <= pend_valid_n;
            m_axis_tdata    <= tdata_n;
            m_axis_tvalid   <= tvalid_n;
            m_axis_tlast    <= tlast_n;
            m_axis_tuser    <= tuser_n;
            error_bad_frame <= ebf_n;
            error_bad_fcs   <= efcs_n;
        end
    end

endmodule

// File: tb/tb_eth_mii_rx_axis.sv
// Self-checking bench for eth_mii_rx_axis: frames built with a reference CRC-32,
// expected output derived from frame-level rules and compared with a monitor log.
module tb_eth_mii_rx_axis;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] mii_rxd = 4'h0;
    logic       mii_rx_dv = 1'b0;
    logic       mii_rx_er = 1'b0;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic       busy, error_bad_frame, error_bad_fcs;

    int tests = 0;
    int fails = 0;

    eth_mii_rx_axis #(.MIN_FRAME_LENGTH(64), .MAX_FRAME_LENGTH(1518)) dut (
        .clk             (clk),
        .rst             (rst),
        .mii_rxd         (mii_rxd),
        .mii_rx_dv       (mii_rx_dv),
        .mii_rx_er       (mii_rx_er),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .busy            (busy),
        .error_bad_frame (error_bad_frame),
        .error_bad_fcs   (error_bad_fcs)
    );

    always #5 clk = ~clk;

    // Output monitor, sampled on the falling edge.
    byte_q_t mon_q;
    int      mon_last, mon_last_pos, mon_ebf, mon_efcs, mon_consec;
    logic    mon_user;
    logic    prev_v = 1'b0;

    always @(negedge clk) begin
        if (m_axis_tvalid) begin
            mon_q.push_back(m_axis_tdata);
            if (prev_v) mon_consec++;
            if (m_axis_tlast) begin
                mon_last++;
                mon_last_pos = mon_q.size();
                mon_user     = m_axis_tuser;
            end
        end
        prev_v = m_axis_tvalid;
        if (error_bad_frame) mon_ebf++;
        if (error_bad_fcs) mon_efcs++;
    end

    // Expected results of one frame.
    byte_q_t exp_q;
    int      exp_last, exp_ebf, exp_efcs;
    logic    exp_user;

    function automatic logic [31:0] crc32_ref(input byte_q_t d);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (d[i]) begin
            c = c ^ {24'h0, d[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic byte_q_t make_frame(input int ndata, input bit corrupt);
        byte_q_t     f;
        logic [31:0] c;
        for (int i = 0; i < ndata; i++) f.push_back((i < 6) ? 8'hFF : 8'($urandom_range(0, 255)));
        c = crc32_ref(f);
        if (corrupt) c = c ^ (32'h1 << $urandom_range(0, 31));
        for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
        return f;
    endfunction

    task automatic model(input byte_q_t f, input bit er);
        int          n = f.size();
        byte_q_t     body;
        logic [31:0] fcs;
        bit          fcs_ok;
        exp_q.delete();
        exp_last = 0; exp_ebf = 1; exp_efcs = 0; exp_user = 1'b1;
        if (n > 1518) begin
            for (int i = 0; i < 1518 - 4; i++) exp_q.push_back(f[i]);
            exp_last = 1;
        end else if (n > 4) begin
            for (int i = 0; i < n - 4; i++) body.push_back(f[i]);
            exp_q    = body;
            fcs      = {f[n-1], f[n-2], f[n-3], f[n-4]};
            fcs_ok   = (crc32_ref(body) == fcs);
            exp_user = er || !fcs_ok || (n < 64);
            exp_ebf  = exp_user ? 1 : 0;
            exp_efcs = fcs_ok ? 0 : 1;
            exp_last = 1;
        end
    endtask

    function automatic int diff_count();
        int d = (mon_q.size() != exp_q.size()) ? 1 : 0;
        foreach (exp_q[i]) if (i < mon_q.size() && mon_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic clear_mon();
        mon_q.delete();
        mon_last = 0; mon_last_pos = 0; mon_ebf = 0; mon_efcs = 0; mon_consec = 0;
        mon_user = 1'b0;
    endtask

    task automatic drive(input logic dv, input logic [3:0] d, input logic er);
        @(posedge clk);
        #1;
        mii_rx_dv = dv; mii_rxd = d; mii_rx_er = er;
    endtask

    // Preamble (15 x 5) + SFD nibble, then bytes low nibble first; stops early at abort_at.
    task automatic send_frame(input byte_q_t f, input int er_at, input int abort_at);
        for (int i = 0; i < 15; i++) drive(1'b1, 4'h5, 1'b0);
        drive(1'b1, 4'hD, 1'b0);
        for (int i = 0; i < f.size(); i++) begin
            if (i == abort_at) return;
            drive(1'b1, f[i][3:0], i == er_at);
            drive(1'b1, f[i][7:4], 1'b0);
        end
        drive(1'b0, 4'h0, 1'b0);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (busy) begin
            fails++;
            $display("FAIL idle_timeout: busy still %0b after %0d cycles, expected 0", busy, k);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, busy, error_bad_frame, error_bad_fcs} !== 14'h0) begin
            fails++;
            $display("FAIL reset_outputs: got tv=%b tl=%b tu=%b td=%h busy=%b ebf=%b efcs=%b, expected all 0",
                     m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, busy, error_bad_frame, error_bad_fcs);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Runs the three 64-byte scenarios: good FCS, flipped FCS bit, rx_er at byte 20.
    task automatic test_frames();
        byte_q_t f;
        string   tag;
        int      nd;
        for (int s = 0; s < 3; s++) begin
            tag = (s == 0) ? "good" : (s == 1) ? "bad_fcs" : "rx_er";
            f = make_frame(60, s == 1);
            model(f, s == 2);
            clear_mon();
            send_frame(f, (s == 2) ? 20 : -1, -1);
            wait_idle();
            nd = diff_count();
            tests++;
            if (nd != 0) begin
                fails++;
                $display("FAIL %s_data: got %0d bytes (%0d diffs), expected %0d bytes", tag, mon_q.size(), nd, exp_q.size());
            end
            tests++;
            if (mon_last != 1 || mon_last_pos != exp_q.size()) begin
                fails++;
                $display("FAIL %s_tlast: got %0d tlast at byte %0d, expected 1 at byte %0d", tag, mon_last, mon_last_pos, exp_q.size());
            end
            tests++;
            if (mon_user !== exp_user) begin
                fails++;
                $display("FAIL %s_tuser: got %b, expected %b", tag, mon_user, exp_user);
            end
            tests++;
            if (mon_ebf != exp_ebf || mon_efcs != exp_efcs) begin
                fails++;
                $display("FAIL %s_errors: got ebf=%0d efcs=%0d, expected ebf=%0d efcs=%0d", tag, mon_ebf, mon_efcs, exp_ebf, exp_efcs);
            end
        end
    endtask

    task automatic test_runt();
        byte_q_t f;
        logic    b1, b2;
        for (int i = 0; i < 3; i++) f.push_back(8'($urandom_range(0, 255)));
        clear_mon();
        send_frame(f, -1, -1);
        @(negedge clk);
        @(negedge clk) b1 = busy;
        @(negedge clk) b2 = busy;
        tests++;
        if (b1 !== 1'b1 || b2 !== 1'b0) begin
            fails++;
            $display("FAIL runt_busy: got busy %b then %b after dv fell, expected 1 then 0", b1, b2);
        end
        wait_idle();
        tests++;
        if (mon_q.size() != 0) begin
            fails++;
            $display("FAIL runt_tvalid: got %0d bytes, expected 0", mon_q.size());
        end
        tests++;
        if (mon_ebf != 1 || mon_efcs != 0) begin
            fails++;
            $display("FAIL runt_errors: got ebf=%0d efcs=%0d, expected ebf=1 efcs=0", mon_ebf, mon_efcs);
        end
    endtask

    // 1600-byte overlength frame, then a good frame must pass clean.
    task automatic test_overlength();
        byte_q_t f;
        int      nd;
        for (int s = 0; s < 2; s++) begin
            f = (s == 0) ? make_frame(1596, 1'b0) : make_frame(60, 1'b0);
            model(f, 1'b0);
            clear_mon();
            send_frame(f, -1, -1);
            wait_idle();
            nd = diff_count();
            tests++;
            if (nd != 0) begin
                fails++;
                $display("FAIL overlen%0d_data: got %0d bytes (%0d diffs), expected %0d bytes", s, mon_q.size(), nd, exp_q.size());
            end
            tests++;
            if (mon_last != 1 || mon_last_pos != exp_q.size() || mon_user !== exp_user) begin
                fails++;
                $display("FAIL overlen%0d_tlast: got %0d tlast at %0d tuser=%b, expected 1 at %0d tuser=%b",
                         s, mon_last, mon_last_pos, mon_user, exp_q.size(), exp_user);
            end
            tests++;
            if (mon_ebf != exp_ebf || mon_efcs != exp_efcs || mon_consec != 0) begin
                fails++;
                $display("FAIL overlen%0d_errors: got ebf=%0d efcs=%0d consec=%0d, expected ebf=%0d efcs=%0d consec=0",
                         s, mon_ebf, mon_efcs, mon_consec, exp_ebf, exp_efcs);
            end
        end
    endtask

    task automatic test_reset_abort();
        byte_q_t f;
        int      nd;
        int      bad_cycles = 0;
        f = make_frame(60, 1'b0);
        clear_mon();
        send_frame(f, -1, 30);
        @(posedge clk);
        #1;
        rst = 1'b1; mii_rx_dv = 1'b0; mii_rxd = 4'h0;
        repeat (3) begin
            @(negedge clk);
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, busy, error_bad_frame, error_bad_fcs} !== 14'h0)
                bad_cycles++;
        end
        tests++;
        if (bad_cycles != 0) begin
            fails++;
            $display("FAIL abort_reset_outputs: got %0d cycles with nonzero outputs, expected 0", bad_cycles);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if (mon_last != 0 || mon_ebf != 0) begin
            fails++;
            $display("FAIL abort_no_tlast: got %0d tlast %0d ebf, expected 0 and 0", mon_last, mon_ebf);
        end
        f = make_frame(60, 1'b0);
        model(f, 1'b0);
        clear_mon();
        send_frame(f, -1, -1);
        wait_idle();
        nd = diff_count();
        tests++;
        if (nd != 0 || mon_last != 1 || mon_user !== 1'b0 || mon_ebf != 0 || mon_efcs != 0) begin
            fails++;
            $display("FAIL abort_next_frame: got %0d bytes (%0d diffs) tlast=%0d tuser=%b ebf=%0d efcs=%0d, expected %0d bytes clean",
                     mon_q.size(), nd, mon_last, mon_user, mon_ebf, mon_efcs, exp_q.size());
        end
    endtask

    task automatic test_random();
        byte_q_t f;
        int      nd, ndata, er_at;
        for (int t = 0; t < 10; t++) begin
            ndata = $urandom_range(1, 100);
            f     = make_frame(ndata, $urandom_range(0, 1) == 1);
            er_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ndata + 3)) : -1;
            model(f, er_at >= 0);
            clear_mon();
            send_frame(f, er_at, -1);
            wait_idle();
            nd = diff_count();
            tests++;
            if (nd != 0) begin
                fails++;
                $display("FAIL rand%0d_data: len %0d got %0d bytes (%0d diffs), expected %0d bytes", t, f.size(), mon_q.size(), nd, exp_q.size());
            end
            tests++;
            if (mon_last != exp_last || (exp_last == 1 && mon_last_pos != exp_q.size())) begin
                fails++;
                $display("FAIL rand%0d_tlast: got %0d tlast at %0d, expected %0d at %0d", t, mon_last, mon_last_pos, exp_last, exp_q.size());
            end
            if (exp_last == 1) begin
                tests++;
                if (mon_user !== exp_user) begin
                    fails++;
                    $display("FAIL rand%0d_tuser: len %0d er_at %0d got %b, expected %b", t, f.size(), er_at, mon_user, exp_user);
                end
            end
            tests++;
            if (mon_ebf != exp_ebf || mon_efcs != exp_efcs || mon_consec != 0) begin
                fails++;
                $display("FAIL rand%0d_errors: got ebf=%0d efcs=%0d consec=%0d, expected ebf=%0d efcs=%0d consec=0",
                         t, mon_ebf, mon_efcs, mon_consec, exp_ebf, exp_efcs);
            end
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_frames();
        test_runt();
        test_overlength();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
